seed_inv_sbox_seq: RTL
======================

# seed_inv_sbox_seq

Sequential inverse of the SEED S-boxes S1 and S2, built on the same composite GF(2^8) arithmetic domain as the forward inversion unit. It takes an S-box output byte and returns the S-box input byte by undoing the affine stage and then raising the result to a fixed power with one shared GF(2^8) multiplier and square-and-multiply. The block sits beside the 8-bit serialized SEED datapath and serves key-schedule checking and fault-detection recomputation. It uses a valid/ready handshake on both sides.

## Interface
- POLY, 8'h63: low byte of the field polynomial x^8+x^6+x^5+x+1; the x^8 term is implicit.
- clk  in  1  single clock; every register uses the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  din and ch are valid.
- in_ready  out  1  block is idle and can accept an input.
- din  in  8  S-box output byte y.
- ch  in  1  1 selects S1^-1; 0 selects S2^-1.
- out_valid  out  1  dout holds a result.
- out_ready  in  1  consumer accepts dout.
- dout  out  8  recovered S-box input byte x.
- busy  out  1  an exponentiation is in progress.

## Operation
- S-box definitions (RFC 4269):
  - S1(x) = A1·x^247 ⊕ 0xA9.
  - S2(x) = A2·x^251 ⊕ 0x38.
- Inverse computation:
  - z = Ak^-1·(y ⊕ ck), where Ak^-1 is the constant GF(2) 8×8 inverse of SEED matrix A1 or A2.
  - x = z^e, with e = 223 (8'b11011111) for S1 and e = 191 (8'b10111111) for S2.
  - These exponents satisfy 247·223 ≡ 251·191 ≡ 1 (mod 255).
- Multiplier:
  - One combinational GF(2^8) multiplier, polynomial basis, reduced by POLY.
  - It is shared between squaring and multiplying.
- FSM states: IDLE, EXP, DONE.
  - IDLE: in_ready=1. On in_valid && in_ready:
    - register z and e (from ch); later changes on ch or din are ignored;
    - set acc=8'h01, bit index=7, phase=SQ;
    - go to EXP.
  - EXP, phase SQ: acc ← acc·acc; phase → MUL.
  - EXP, phase MUL:
    - acc ← e[bit] ? acc·z : acc;
    - if bit==0: dout ← result, go to DONE; otherwise bit−1, phase → SQ.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Zero input to the exponentiation (z=0) yields x=0 with no special case.
- in_valid is ignored outside IDLE. dout holds its value until the next result is loaded.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, dout=8'h00, state=IDLE, acc=8'h01.
- Reset is asynchronous at any point, mid-EXP included. Any partial result is discarded, with no output pulse.
- Latency:
  - Input accepted at edge T; EXP occupies edges T+1..T+16.
  - out_valid rises after edge T+16, i.e. 16 cycles.
- busy=1 exactly while in EXP.
- Output handshake:
  - out_valid && out_ready at edge D → IDLE. in_ready=1 and out_valid=0 in cycle D+1.
  - A new input can be accepted at edge D+1.
  - Minimum period: 18 cycles per byte.
- Backpressure: out_ready=0 holds DONE indefinitely; dout and out_valid stay stable.
- Simultaneous in_valid in DONE: not accepted until after the output handshake.

## Configuration
- SEED_INVSBOX_SKIP0_EN defined: the MUL phase is skipped for exponent bits equal to 0 (after SQ, go directly to the next bit).
  - Both exponents contain exactly one 0 bit, so latency is 15 cycles for S1 and for S2.
  - The final bit of both exponents is 1, so termination is unchanged.
- Undefined: fixed 16-cycle, data-independent latency. This is the default for side-channel-sensitive builds.

## Test plan
- Post-reset and mid-operation reset:
  - reset → in_ready=1, out_valid=0, dout=00.
  - Assert rst at EXP cycle 5 → IDLE, no out_valid. A following input completes normally.
- Known inverse values:
  - ch=1, din=A9 → dout=00.
  - ch=1, din=85 → dout=01.
  - ch=0, din=38 → dout=00.
  - ch=0, din=E8 → dout=01.
  - out_valid must rise exactly 16 cycles after acceptance (15 with SEED_INVSBOX_SKIP0_EN).
- Exhaustive round trip:
  - For all 256 x and both ch, drive din=S(x) from the RFC 4269 tables → dout=x.
  - Drive the same set again with out_ready tied to 1 → back-to-back throughput of one result per 18 cycles.
- Backpressure: hold out_ready=0 for 40 cycles after a result.
  - dout stays stable; in_ready=0.
  - in_valid pulses in that window are ignored.
  - Releasing out_ready gives one handshake, then in_ready=1.
- Input stability: change ch and din during EXP → result matches the values captured at acceptance.

Source files
------------

// File: rtl/seed_inv_sbox_seq.sv
// Sequential inverse of the SEED S-boxes S1/S2: inverse affine stage, then x = z^e by square-and-multiply
// on one shared GF(2^8) multiplier. Define SEED_INVSBOX_SKIP0_EN to skip the multiply phase on zero exponent bits.
module seed_inv_sbox_seq #(
  parameter logic [7:0] POLY = 8'h63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] din,
  input  logic       ch,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] dout,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic {
    PH_SQ  = 1'b0,
    PH_MUL = 1'b1
  } phase_t;

  localparam logic [7:0] C1 = 8'hA9;
  localparam logic [7:0] C2 = 8'h38;
  localparam logic [7:0] E1 = 8'hDF;
  localparam logic [7:0] E2 = 8'hBF;

  // Columns of A1^-1 and A2^-1: entry [i] is the image of basis bit i.
  localparam logic [7:0][7:0] A1_INV = 64'hDE35_88E9_9C15_E325;
  localparam logic [7:0][7:0] A2_INV = 64'h9C88_3515_DEE3_E925;

  state_t     state_q, state_d;
  phase_t     phase_q, phase_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] z_q, z_d;
  logic [7:0] e_q, e_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] dout_q, dout_d;

  // Inverse affine stage on the incoming byte.
  logic [7:0] aff_y;
  logic [7:0] aff_z;
  logic [7:0] aff_t [8];

  assign aff_y = din ^ (ch ? C1 : C2);

  for (genvar gi = 0; gi < 8; gi++) begin : g_affine
    assign aff_t[gi] = aff_y[gi] ? (ch ? A1_INV[gi] : A2_INV[gi]) : 8'h00;
  end

  always_comb begin
    aff_z = 8'h00;
    for (int i = 0; i < 8; i++) begin
      aff_z = aff_z ^ aff_t[i];
    end
  end

  // Shared polynomial-basis multiplier; operand b is acc while squaring, z while multiplying.
  logic [7:0] mul_a, mul_b, mul_p;
  logic [7:0] mul_sh;

  assign mul_a = acc_q;
  assign mul_b = (phase_q == PH_SQ) ? acc_q : z_q;

  always_comb begin
    mul_p  = 8'h00;
    mul_sh = mul_a;
    for (int i = 0; i < 8; i++) begin
      if (mul_b[i]) begin
        mul_p = mul_p ^ mul_sh;
      end
      mul_sh = {mul_sh[6:0], 1'b0} ^ (mul_sh[7] ? POLY : 8'h00);
    end
  end

  logic [7:0] mul_res;
  assign mul_res = e_q[bit_q] ? mul_p : acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= PH_SQ;
      acc_q   <= 8'h01;
      z_q     <= 8'h00;
      e_q     <= 8'h00;
      bit_q   <= 3'd7;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      e_q     <= e_d;
      bit_q   <= bit_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    acc_d   = acc_q;
    z_d     = z_q;
    e_d     = e_q;
    bit_d   = bit_q;
    dout_d  = dout_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          z_d     = aff_z;
          e_d     = ch ? E1 : E2;
          acc_d   = 8'h01;
          bit_d   = 3'd7;
          phase_d = PH_SQ;
          state_d = S_EXP;
        end
      end

      S_EXP: begin
        if (phase_q == PH_SQ) begin
          acc_d = mul_p;
`ifdef SEED_INVSBOX_SKIP0_EN
          if (!e_q[bit_q] && (bit_q != 3'd0)) begin
            bit_d = bit_q - 3'd1;
          end else begin
            phase_d = PH_MUL;
          end
`else
          phase_d = PH_MUL;
`endif
        end else begin
          acc_d = mul_res;
          if (bit_q == 3'd0) begin
            dout_d  = mul_res;
            state_d = S_DONE;
          end else begin
            bit_d   = bit_q - 3'd1;
            phase_d = PH_SQ;
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_EXP);
  assign dout      = dout_q;

endmodule
